// File: rtl/control_sequencer.sv
// Hardwired control sequencer: IDLE, T0..T6, HALT; fetch in T0-T2, execute from T3.
// Defining MULDIV_EN adds MUL/DIV sequencing and state T6; otherwise both opcodes are illegal.
module control_sequencer (
    input  logic        clock,
    input  logic        clear,
    input  logic [31:0] IR,
    input  logic        stall,
    output logic [15:0] regIn,
    output logic [15:0] regOut,
    output logic        HiIn,
    output logic        LoIn,
    output logic        ZIn,
    output logic        PCIn,
    output logic        MDRIn,
    output logic        YIn,
    output logic        IRIn,
    output logic        MARIn,
    output logic        HiOut,
    output logic        LoOut,
    output logic        ZHiOut,
    output logic        ZLoOut,
    output logic        PCOut,
    output logic        MDROut,
    output logic        MDRread,
    output logic        IncPC,
    output logic [4:0]  ALUcode,
    output logic        illegal,
    output logic        halted
);

    typedef enum logic [3:0] {
        IDLE = 4'd0,
        T0   = 4'd1,
        T1   = 4'd2,
        T2   = 4'd3,
        T3   = 4'd4,
        T4   = 4'd5,
        T5   = 4'd6,
`ifdef MULDIV_EN
        T6   = 4'd7,
`endif
        HALT = 4'd8
    } state_t;

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_SHR  = 5'b00111;
    localparam logic [4:0] OP_SHRA = 5'b01000;
    localparam logic [4:0] OP_SHL  = 5'b01001;
    localparam logic [4:0] OP_ROR  = 5'b01010;
    localparam logic [4:0] OP_ROL  = 5'b01011;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    state_t      state;
    state_t      next_state;
    logic [4:0]  opcode;
    logic [15:0] sel_ra;
    logic [15:0] sel_rb;
    logic [15:0] sel_rc;
    logic        is_bin;
    logic        is_una;
    logic        is_nop;
    logic        is_halt;
    logic        is_muldiv;
    logic        is_illegal;
    logic        unused_ir;

    assign opcode    = IR[31:27];
    assign sel_ra    = 16'd1 << IR[26:23];
    assign sel_rb    = 16'd1 << IR[22:19];
    assign sel_rc    = 16'd1 << IR[18:15];
    assign unused_ir = ^IR[14:0];

    always_comb begin
        is_bin    = 1'b0;
        is_una    = 1'b0;
        is_nop    = 1'b0;
        is_halt   = 1'b0;
        is_muldiv = 1'b0;
        case (opcode)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR,
            OP_SHRA, OP_SHL, OP_ROR, OP_ROL: is_bin    = 1'b1;
            OP_NEG, OP_NOT:                  is_una    = 1'b1;
            OP_NOP:                          is_nop    = 1'b1;
            OP_HALT:                         is_halt   = 1'b1;
`ifdef MULDIV_EN
            OP_MUL, OP_DIV:                  is_muldiv = 1'b1;
`endif
            default: ;
        endcase
        is_illegal = !(is_bin || is_una || is_nop || is_halt || is_muldiv);
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Stall only freezes the state; the per-state decode is untouched so strobes repeat on resume.
    always_comb begin
        next_state = state;
        if (!stall) begin
            case (state)
                IDLE: next_state = T0;
                T0:   next_state = T1;
                T1:   next_state = T2;
                T2: begin
                    if (is_nop) begin
                        next_state = T0;
                    end else if (is_halt) begin
                        next_state = HALT;
                    end else begin
                        next_state = T3;
                    end
                end
                T3:   next_state = (is_bin || is_una || is_muldiv) ? T4 : T0;
                T4:   next_state = is_una ? T0 : T5;
`ifdef MULDIV_EN
                T5:   next_state = is_muldiv ? T6 : T0;
                T6:   next_state = T0;
`else
                T5:   next_state = T0;
`endif
                HALT: next_state = HALT;
                default: next_state = IDLE;
            endcase
        end
    end

    always_comb begin
        regIn   = '0;
        regOut  = '0;
        HiIn    = 1'b0;
        LoIn    = 1'b0;
        ZIn     = 1'b0;
        PCIn    = 1'b0;
        MDRIn   = 1'b0;
        YIn     = 1'b0;
        IRIn    = 1'b0;
        MARIn   = 1'b0;
        HiOut   = 1'b0;
        LoOut   = 1'b0;
        ZHiOut  = 1'b0;
        ZLoOut  = 1'b0;
        PCOut   = 1'b0;
        MDROut  = 1'b0;
        MDRread = 1'b0;
        IncPC   = 1'b0;
        ALUcode = '0;
        illegal = 1'b0;
        halted  = 1'b0;
        case (state)
            T0: begin
                PCOut   = 1'b1;
                MARIn   = 1'b1;
                IncPC   = 1'b1;
                ZIn     = 1'b1;
                ALUcode = OP_ADD;
            end
            T1: begin
                ZLoOut  = 1'b1;
                PCIn    = 1'b1;
                MDRread = 1'b1;
                MDRIn   = 1'b1;
            end
            T2: begin
                MDROut = 1'b1;
                IRIn   = 1'b1;
            end
            T3: begin
                if (is_bin) begin
                    regOut = sel_rb;
                    YIn    = 1'b1;
                end else if (is_una) begin
                    regOut  = sel_rb;
                    ZIn     = 1'b1;
                    ALUcode = opcode;
                end else if (is_muldiv) begin
                    regOut = sel_ra;
                    YIn    = 1'b1;
                end else if (is_illegal) begin
                    illegal = 1'b1;
                end
            end
            T4: begin
                if (is_bin) begin
                    regOut  = sel_rc;
                    ZIn     = 1'b1;
                    ALUcode = opcode;
                end else if (is_una) begin
                    ZLoOut = 1'b1;
                    regIn  = sel_ra;
                end else if (is_muldiv) begin
                    regOut  = sel_rb;
                    ZIn     = 1'b1;
                    ALUcode = opcode;
                end
            end
            T5: begin
                if (is_bin) begin
                    ZLoOut = 1'b1;
                    regIn  = sel_ra;
                end else if (is_muldiv) begin
                    ZLoOut = 1'b1;
                    LoIn   = 1'b1;
                end
            end
`ifdef MULDIV_EN
            T6: begin
                ZHiOut = 1'b1;
                HiIn   = 1'b1;
            end
`endif
            HALT: halted = 1'b1;
            default: ;
        endcase
        // halted is a status level, not a strobe, so it survives a stall.
        if (stall) begin
            regIn   = '0;
            regOut  = '0;
            HiIn    = 1'b0;
            LoIn    = 1'b0;
            ZIn     = 1'b0;
            PCIn    = 1'b0;
            MDRIn   = 1'b0;
            YIn     = 1'b0;
            IRIn    = 1'b0;
            MARIn   = 1'b0;
            HiOut   = 1'b0;
            LoOut   = 1'b0;
            ZHiOut  = 1'b0;
            ZLoOut  = 1'b0;
            PCOut   = 1'b0;
            MDROut  = 1'b0;
            MDRread = 1'b0;
            IncPC   = 1'b0;
            ALUcode = '0;
            illegal = 1'b0;
        end
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: fetch, ADD, NEG, illegal, stall, clear, HALT, MUL, NOP.
module tb_control_sequencer;

    logic        clock;
    logic        clear;
    logic [31:0] IR;
    logic        stall;
    logic [15:0] regIn;
    logic [15:0] regOut;
    logic        HiIn, LoIn, ZIn, PCIn, MDRIn, YIn, IRIn, MARIn;
    logic        HiOut, LoOut, ZHiOut, ZLoOut, PCOut, MDROut;
    logic        MDRread, IncPC;
    logic [4:0]  ALUcode;
    logic        illegal, halted;

    int n_total = 0;
    int n_pass  = 0;

    localparam logic [17:0] S_HIIN    = 18'h20000;
    localparam logic [17:0] S_LOIN    = 18'h10000;
    localparam logic [17:0] S_ZIN     = 18'h08000;
    localparam logic [17:0] S_PCIN    = 18'h04000;
    localparam logic [17:0] S_MDRIN   = 18'h02000;
    localparam logic [17:0] S_YIN     = 18'h01000;
    localparam logic [17:0] S_IRIN    = 18'h00800;
    localparam logic [17:0] S_MARIN   = 18'h00400;
    localparam logic [17:0] S_HIOUT   = 18'h00200;
    localparam logic [17:0] S_LOOUT   = 18'h00100;
    localparam logic [17:0] S_ZHIOUT  = 18'h00080;
    localparam logic [17:0] S_ZLOOUT  = 18'h00040;
    localparam logic [17:0] S_PCOUT   = 18'h00020;
    localparam logic [17:0] S_MDROUT  = 18'h00010;
    localparam logic [17:0] S_MDRREAD = 18'h00008;
    localparam logic [17:0] S_INCPC   = 18'h00004;
    localparam logic [17:0] S_ILL     = 18'h00002;
    localparam logic [17:0] S_HALTED  = 18'h00001;

    localparam logic [31:0] IR_ADD  = 32'h19180000;
    localparam logic [31:0] IR_NEG  = 32'h8A800000;
    localparam logic [31:0] IR_BAD  = 32'hF8000000;
    localparam logic [31:0] IR_HALT = 32'hD8000000;
    localparam logic [31:0] IR_MUL  = 32'h78900000;
    localparam logic [31:0] IR_NOP  = 32'hD0000000;

    logic [54:0] outs;
    assign outs = {regIn, regOut,
                   HiIn, LoIn, ZIn, PCIn, MDRIn, YIn, IRIn, MARIn,
                   HiOut, LoOut, ZHiOut, ZLoOut, PCOut, MDROut,
                   MDRread, IncPC, illegal, halted, ALUcode};

    control_sequencer dut (
        .clock(clock), .clear(clear), .IR(IR), .stall(stall),
        .regIn(regIn), .regOut(regOut),
        .HiIn(HiIn), .LoIn(LoIn), .ZIn(ZIn), .PCIn(PCIn), .MDRIn(MDRIn),
        .YIn(YIn), .IRIn(IRIn), .MARIn(MARIn),
        .HiOut(HiOut), .LoOut(LoOut), .ZHiOut(ZHiOut), .ZLoOut(ZLoOut),
        .PCOut(PCOut), .MDROut(MDROut),
        .MDRread(MDRread), .IncPC(IncPC), .ALUcode(ALUcode),
        .illegal(illegal), .halted(halted)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [54:0] mk(input logic [15:0] ri, input logic [15:0] ro,
                                       input logic [17:0] s, input logic [4:0] alu);
        return {ri, ro, s, alu};
    endfunction

    localparam logic [54:0] E_ZERO = 55'd0;

    task automatic chk(input string tag, input logic [54:0] exp);
        n_total++;
        assert (outs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, outs, exp);
    endtask

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    logic [54:0] e_t0, e_t1, e_t2;

    initial begin
        e_t0 = mk(16'h0, 16'h0, S_PCOUT | S_MARIN | S_INCPC | S_ZIN, 5'b00011);
        e_t1 = mk(16'h0, 16'h0, S_ZLOOUT | S_PCIN | S_MDRREAD | S_MDRIN, 5'b00000);
        e_t2 = mk(16'h0, 16'h0, S_MDROUT | S_IRIN, 5'b00000);

        clear = 1'b1;
        stall = 1'b0;
        IR    = IR_ADD;
        #1 chk("reset", E_ZERO);
        step;
        step;
        chk("reset_held", E_ZERO);

        // ADD R2=R3+R0
        clear = 1'b0;
        #1 chk("idle", E_ZERO);
        step; chk("add_t0", e_t0);
        step; chk("add_t1", e_t1);
        step; chk("add_t2", e_t2);
        step; chk("add_t3", mk(16'h0, 16'h0008, S_YIN, 5'b00000));
        step; chk("add_t4", mk(16'h0, 16'h0001, S_ZIN, 5'b00011));
        step; chk("add_t5", mk(16'h0004, 16'h0, S_ZLOOUT, 5'b00000));
        step; chk("add_next_t0", e_t0);

        // NEG R5=-R0
        IR = IR_NEG;
        step; chk("neg_t1", e_t1);
        step; chk("neg_t2", e_t2);
        step; chk("neg_t3", mk(16'h0, 16'h0001, S_ZIN, 5'b10001));
        step; chk("neg_t4", mk(16'h0020, 16'h0, S_ZLOOUT, 5'b00000));
        step; chk("neg_next_t0", e_t0);

        // illegal opcode 11111
        IR = IR_BAD;
        step; chk("ill_t1", e_t1);
        step; chk("ill_t2", e_t2);
        step; chk("ill_t3", mk(16'h0, 16'h0, S_ILL, 5'b00000));
        step; chk("ill_next_t0", e_t0);

        // ADD with a 3-cycle stall in T4
        IR = IR_ADD;
        step; chk("stl_t1", e_t1);
        step; chk("stl_t2", e_t2);
        step; chk("stl_t3", mk(16'h0, 16'h0008, S_YIN, 5'b00000));
        step; chk("stl_t4", mk(16'h0, 16'h0001, S_ZIN, 5'b00011));
        stall = 1'b1;
        #1 chk("stl_c1", E_ZERO);
        step; chk("stl_c2", E_ZERO);
        step; chk("stl_c3", E_ZERO);
        step;
        stall = 1'b0;
        #1 chk("stl_t4_again", mk(16'h0, 16'h0001, S_ZIN, 5'b00011));
        step; chk("stl_t5", mk(16'h0004, 16'h0, S_ZLOOUT, 5'b00000));
        step; chk("stl_next_t0", e_t0);

        // clear during T4 of an ADD
        step; chk("clr_t1", e_t1);
        step; chk("clr_t2", e_t2);
        step; chk("clr_t3", mk(16'h0, 16'h0008, S_YIN, 5'b00000));
        step; chk("clr_t4", mk(16'h0, 16'h0001, S_ZIN, 5'b00011));
        clear = 1'b1;
        #1 chk("clr_immediate", E_ZERO);
        step; chk("clr_held", E_ZERO);
        clear = 1'b0;
        #1 chk("clr_idle", E_ZERO);
        step; chk("clr_t0", e_t0);

        // HALT
        IR = IR_HALT;
        step; chk("hlt_t1", e_t1);
        step; chk("hlt_t2", e_t2);
        step; chk("hlt_enter", mk(16'h0, 16'h0, S_HALTED, 5'b00000));
        for (int i = 0; i < 10; i++) begin
            step; chk("hlt_stay", mk(16'h0, 16'h0, S_HALTED, 5'b00000));
        end
        clear = 1'b1;
        #1 chk("hlt_clear", E_ZERO);
        step;
        clear = 1'b0;
        #1 chk("hlt_idle", E_ZERO);
        step; chk("hlt_t0", e_t0);

        // MUL Ra=R1, Rb=R2
        IR = IR_MUL;
        step; chk("mul_t1", e_t1);
        step; chk("mul_t2", e_t2);
`ifdef MULDIV_EN
        step; chk("mul_t3", mk(16'h0, 16'h0002, S_YIN, 5'b00000));
        step; chk("mul_t4", mk(16'h0, 16'h0004, S_ZIN, 5'b01111));
        step; chk("mul_t5", mk(16'h0, 16'h0, S_ZLOOUT | S_LOIN, 5'b00000));
        step; chk("mul_t6", mk(16'h0, 16'h0, S_ZHIOUT | S_HIIN, 5'b00000));
`else
        step; chk("mul_ill_t3", mk(16'h0, 16'h0, S_ILL, 5'b00000));
`endif
        step; chk("mul_next_t0", e_t0);

        // NOP returns from T2 to T0
        IR = IR_NOP;
        step; chk("nop_t1", e_t1);
        step; chk("nop_t2", e_t2);
        step; chk("nop_next_t0", e_t0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
